// File: rtl/hazard_stall_unit_if.sv
// Hazard/stall control bus between the pipeline datapath and hazard_stall_unit.
// Optional statistics outputs exist only when HAZARD_STATS_EN is defined.
interface hazard_stall_unit_if;
    logic [4:0]  IF_ID_rs;
    logic [4:0]  IF_ID_rt;
    logic        IF_ID_useRt;
    logic [4:0]  ID_EX_rt;
    logic        ID_EX_memRead;
    logic        branchTaken_E;
    logic        md_start_E;
    logic        stallF;
    logic        stallD;
    logic        stallE;
    logic        flushD;
    logic        flushE;
    logic        flushM;
    logic        md_busy;
    logic        md_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] lu_stall_cnt;
    logic [31:0] md_stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_useRt, ID_EX_rt, ID_EX_memRead,
        output branchTaken_E, md_start_E,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
        input  md_busy, md_done,
        input  lu_stall_cnt, md_stall_cnt, flush_cnt
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_useRt, ID_EX_rt, ID_EX_memRead,
        input  branchTaken_E, md_start_E,
        output stallF, stallD, stallE, flushD, flushE, flushM,
        output md_busy, md_done,
        output lu_stall_cnt, md_stall_cnt, flush_cnt
    );
`else
    modport master (
        output IF_ID_rs, IF_ID_rt, IF_ID_useRt, ID_EX_rt, ID_EX_memRead,
        output branchTaken_E, md_start_E,
        input  stallF, stallD, stallE, flushD, flushE, flushM,
        input  md_busy, md_done
    );

    modport slave (
        input  IF_ID_rs, IF_ID_rt, IF_ID_useRt, ID_EX_rt, ID_EX_memRead,
        input  branchTaken_E, md_start_E,
        output stallF, stallD, stallE, flushD, flushE, flushM,
        output md_busy, md_done
    );
`endif
endinterface

// File: rtl/hazard_stall_unit.sv
// Load-use / taken-branch / multi-cycle MUL-DIV stall and flush control.
// Optional macro HAZARD_STATS_EN adds saturating 32-bit event counters.
module hazard_stall_unit #(
    parameter int MD_LATENCY = 4,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              reset,
    hazard_stall_unit_if.slave bus
);

    if (MD_LATENCY < 2) begin : g_chk_lat
        $error("MD_LATENCY must be >= 2");
    end
    if ((2 ** CNT_W) <= MD_LATENCY) begin : g_chk_cnt
        $error("CNT_W too narrow for MD_LATENCY");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic w_lu;
    logic w_br;
    logic w_md_stall;
    logic w_md_done;
    logic w_md_busy;

    assign w_lu = bus.ID_EX_memRead && (bus.ID_EX_rt != 5'd0) &&
                  ((bus.ID_EX_rt == bus.IF_ID_rs) ||
                   (bus.IF_ID_useRt && (bus.ID_EX_rt == bus.IF_ID_rt)));

    assign w_br = bus.branchTaken_E;

    // md_start_E only matters in IDLE; in BUSY it is the same instruction.
    assign w_md_stall = ((r_state == IDLE) && bus.md_start_E) ||
                        ((r_state == BUSY) && (r_cnt > CNT_W'(1)));
    assign w_md_done  = (r_state == BUSY) && (r_cnt == CNT_W'(1));
    assign w_md_busy  = ((r_state == IDLE) && bus.md_start_E) ||
                        (r_state == BUSY);

    // Priority: MD stall holds everything, then branch flush, then load-use.
    always_comb begin
        bus.stallF  = w_md_stall || (!w_br && w_lu);
        bus.stallD  = w_md_stall || (!w_br && w_lu);
        bus.stallE  = w_md_stall;
        bus.flushD  = !w_md_stall && w_br;
        bus.flushE  = !w_md_stall && (w_br || w_lu);
        bus.flushM  = w_md_stall;
        bus.md_busy = w_md_busy;
        bus.md_done = w_md_done;
    end

    // MD residency FSM: counts down the remaining EX cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (bus.md_start_E) begin
                        r_state <= BUSY;
                        r_cnt   <= CNT_W'(MD_LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (r_cnt > CNT_W'(1)) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STATS_EN
    logic [31:0] r_lu_cnt;
    logic [31:0] r_md_cnt;
    logic [31:0] r_fl_cnt;
    logic        w_lu_ev;
    logic        w_fl_ev;

    assign w_lu_ev = w_lu && !w_br && !w_md_stall;
    assign w_fl_ev = w_br && !w_md_stall;

    // Saturating counters of cycles each hazard class drove the controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lu_cnt <= '0;
            r_md_cnt <= '0;
            r_fl_cnt <= '0;
        end else begin
            if (w_lu_ev && (r_lu_cnt != '1)) r_lu_cnt <= r_lu_cnt + 32'd1;
            if (w_md_stall && (r_md_cnt != '1)) r_md_cnt <= r_md_cnt + 32'd1;
            if (w_fl_ev && (r_fl_cnt != '1)) r_fl_cnt <= r_fl_cnt + 32'd1;
        end
    end

    assign bus.lu_stall_cnt = r_lu_cnt;
    assign bus.md_stall_cnt = r_md_cnt;
    assign bus.flush_cnt    = r_fl_cnt;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed-vector bench for hazard_stall_unit (MD_LATENCY=4).
// Output vector order: stallF stallD stallE flushD flushE flushM md_busy md_done.
module tb_hazard_stall_unit;

    logic clk;
    logic reset;

    hazard_stall_unit_if bus ();

    hazard_stall_unit #(.MD_LATENCY(4), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] w_outs;
    assign w_outs = {bus.stallF, bus.stallD, bus.stallE, bus.flushD,
                     bus.flushE, bus.flushM, bus.md_busy, bus.md_done};

    localparam logic [7:0] ZERO  = 8'b0000_0000;
    localparam logic [7:0] LU    = 8'b1100_1000;
    localparam logic [7:0] BR    = 8'b0001_1000;
    localparam logic [7:0] MDS   = 8'b1110_0110;
    localparam logic [7:0] MDD   = 8'b0000_0011;
    localparam logic [7:0] MDDLU = 8'b1100_1011;

    typedef struct {
        string      nm;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rt;
        logic [4:0] ex_rt;
        logic       mem_rd;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    int n_run;
    int n_fail;

    task automatic chk(input string nm, input logic [7:0] exp);
        n_run++;
        if (w_outs !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b expected=%b", nm, w_outs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                         input logic use_rt, input logic [4:0] ex_rt,
                         input logic mem_rd, input logic br,
                         input logic md);
        bus.IF_ID_rs      = rs;
        bus.IF_ID_rt      = rt;
        bus.IF_ID_useRt   = use_rt;
        bus.ID_EX_rt      = ex_rt;
        bus.ID_EX_memRead = mem_rd;
        bus.branchTaken_E = br;
        bus.md_start_E    = md;
    endtask

    // Next cycle: drive at the falling edge, sample 1 ns later.
    task automatic step(input logic [4:0] rs, input logic [4:0] rt,
                        input logic use_rt, input logic [4:0] ex_rt,
                        input logic mem_rd, input logic br,
                        input logic md);
        @(negedge clk);
        drive(rs, rt, use_rt, ex_rt, mem_rd, br, md);
        #1;
    endtask

    vec_t vt[10];

    initial begin
        n_run  = 0;
        n_fail = 0;

        vt[0] = '{"idle",       5'd0,  5'd0, 1'b0, 5'd0,  1'b0, 1'b0, ZERO};
        vt[1] = '{"lu_rs",      5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b0, LU};
        vt[2] = '{"lu_r0",      5'd0,  5'd0, 1'b1, 5'd0,  1'b1, 1'b0, ZERO};
        vt[3] = '{"lu_rt_use",  5'd3,  5'd8, 1'b1, 5'd8,  1'b1, 1'b0, LU};
        vt[4] = '{"lu_rt_nouse",5'd3,  5'd8, 1'b0, 5'd8,  1'b1, 1'b0, ZERO};
        vt[5] = '{"no_load",    5'd5,  5'd5, 1'b1, 5'd5,  1'b0, 1'b0, ZERO};
        vt[6] = '{"br_only",    5'd1,  5'd2, 1'b1, 5'd9,  1'b0, 1'b1, BR};
        vt[7] = '{"br_and_lu",  5'd5,  5'd0, 1'b0, 5'd5,  1'b1, 1'b1, BR};
        vt[8] = '{"lu_rt_mix",  5'd6,  5'd5, 1'b1, 5'd5,  1'b1, 1'b0, LU};
        vt[9] = '{"lu_r31",     5'd31, 5'd0, 1'b0, 5'd31, 1'b1, 1'b0, LU};

        drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("reset_hold", ZERO);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("reset_rel", ZERO);

        for (int i = 0; i < 10; i++) begin
            step(vt[i].rs, vt[i].rt, vt[i].use_rt, vt[i].ex_rt,
                 vt[i].mem_rd, vt[i].br, 1'b0);
            chk(vt[i].nm, vt[i].exp);
        end

        // Two back-to-back MD sequences with md_start_E held high.
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 3; c++) begin
                step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
                chk($sformatf("md%0d_stall%0d", k, c), MDS);
            end
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("md%0d_done", k), MDD);
        end
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("md_idle", ZERO);

        // Load-use during MD stall is held off; branch is ignored there.
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("md_lu_c1", MDS);
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1);
        chk("md_br_ign", MDS);
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("md_lu_c3", MDS);
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("md_lu_done", MDDLU);
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("lu_after_md", LU);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("lu_clear", ZERO);

        // Reset after two stall cycles abandons the sequence.
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_md_c1", MDS);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_md_c2", MDS);
        @(negedge clk);
        #1 chk("rst_md_c3", MDS);
        #1;
        reset = 1'b1;
        bus.md_start_E = 1'b0;
        #1 chk("rst_async", ZERO);
        @(posedge clk);
        #1 chk("rst_held", ZERO);
        @(negedge clk);
        reset = 1'b0;
        #1 chk("rst_rel0", ZERO);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("rst_nodone", ZERO);
        for (int c = 0; c < 3; c++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("restart_stall%0d", c), MDS);
        end
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("restart_done", MDD);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("restart_idle", ZERO);

`ifdef HAZARD_STATS_EN
        @(negedge clk);
        reset = 1'b1;
        #1;
        reset = 1'b0;
        step(5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, c < 3);
        end
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        n_run++;
        if (bus.lu_stall_cnt !== 32'd1) begin
            n_fail++;
            $display("FAIL lu_stall_cnt got=%0d expected=1", bus.lu_stall_cnt);
        end
        n_run++;
        if (bus.md_stall_cnt !== 32'd3) begin
            n_fail++;
            $display("FAIL md_stall_cnt got=%0d expected=3", bus.md_stall_cnt);
        end
        n_run++;
        if (bus.flush_cnt !== 32'd2) begin
            n_fail++;
            $display("FAIL flush_cnt got=%0d expected=2", bus.flush_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
